filter_event_ctrl: RTL and testbench

Sequencing and event-capture controller placed directly after the trapezoidal shaping filter. On enable it holds the filter in clear for a fixed settling period, then arms. It detects threshold crossings on the filtered stream and tracks each pulse maximum. Each pulse's peak amplitude and timestamp are queued in a small first-word-fall-through (FWFT) FIFO and delivered to readout over a valid/ready handshake.

---
 rtl/filter_event_ctrl_if.sv | 29 ++
 rtl/filter_event_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_filter_event_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_event_ctrl_if.sv
// Port bundle for filter_event_ctrl: run control, filter sample stream and readout event stream.
// master drives run control, samples and ev_ready; slave (the controller) drives clear, events and drop count.
interface filter_event_ctrl_if #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_W             = 32
);
  logic                               enable;
  logic signed [SIZE_FILTER_DATA-1:0] threshold;
  logic [7:0]                         holdoff;
  logic                               sample_valid;
  logic signed [SIZE_FILTER_DATA-1:0] filter_data;
  logic                               filter_clear;
  logic                               ev_valid;
  logic                               ev_ready;
  logic signed [SIZE_FILTER_DATA-1:0] ev_amp;
  logic [TS_W-1:0]                    ev_time;
  logic                               ev_pileup;
  logic [7:0]                         drop_cnt;

  modport master (
    output enable, threshold, holdoff, sample_valid, filter_data, ev_ready,
    input  filter_clear, ev_valid, ev_amp, ev_time, ev_pileup, drop_cnt
  );

  modport slave (
    input  enable, threshold, holdoff, sample_valid, filter_data, ev_ready,
    output filter_clear, ev_valid, ev_amp, ev_time, ev_pileup, drop_cnt
  );
endinterface

// File: rtl/filter_event_ctrl.sv
// Flush/arm sequencer and pulse peak capture behind the trapezoidal filter, with an FWFT event queue.
// Event pushed on the edge registering the end-of-pulse sample, visible one cycle later; full queue drops and counts.

// Generic first-word-fall-through FIFO; head valid one cycle after write.
// A write into a full FIFO is accepted only alongside a same-cycle read.
module event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign rd_vld = (count != '0);
  assign wr_rdy = (count != FULL_CNT) || rd_rdy;
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module filter_event_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_W             = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int FLUSH_LEN        = 64
) (
  input logic                clk,
  input logic                reset,
  filter_event_ctrl_if.slave bus
);
  localparam int W     = SIZE_FILTER_DATA;
  localparam int CNT_W = ($clog2(FLUSH_LEN) > 8) ? $clog2(FLUSH_LEN) : 8;

  typedef enum logic [2:0] {IDLE, FLUSH, ARMED, PEAK, HOLDOFF} state_t;

  typedef struct packed {
    logic signed [W-1:0] amp;
    logic [TS_W-1:0]     ts;
    logic                pileup;
  } event_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [TS_W-1:0]     ts, ts_nxt, peak_ts, peak_ts_nxt;
  logic signed [W-1:0] peak, peak_nxt;
  logic                prev_above, prev_above_nxt;
  logic                pileup, pileup_nxt;
  logic                above, push, push_rdy, head_vld;
  logic [7:0]          drop_cnt_q;
  event_t              push_ev, head_ev, last_ev, shown_ev;

  assign above = bus.filter_data > bus.threshold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ts         <= '0;
      peak       <= '0;
      peak_ts    <= '0;
      prev_above <= 1'b0;
      pileup     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ts         <= ts_nxt;
      peak       <= peak_nxt;
      peak_ts    <= peak_ts_nxt;
      prev_above <= prev_above_nxt;
      pileup     <= pileup_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ts_nxt         = ts;
    peak_nxt       = peak;
    peak_ts_nxt    = peak_ts;
    prev_above_nxt = prev_above;
    pileup_nxt     = pileup;
    push           = 1'b0;

    if (state inside {ARMED, PEAK, HOLDOFF}) begin
      ts_nxt = ts + 1'b1;
      if (bus.sample_valid) prev_above_nxt = above;
    end

    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_W'(FLUSH_LEN - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt      = ARMED;
          ts_nxt         = '0;
          prev_above_nxt = 1'b0;
          pileup_nxt     = 1'b0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ARMED: begin
        if (bus.sample_valid && above && !prev_above) begin
          state_nxt   = PEAK;
          peak_nxt    = bus.filter_data;
          peak_ts_nxt = ts;
        end
      end
      PEAK: begin
        if (bus.sample_valid) begin
          if (!above) begin
            push       = 1'b1;
            pileup_nxt = 1'b0;
            if (bus.holdoff == '0) begin
              state_nxt = ARMED;
            end else begin
              state_nxt = HOLDOFF;
              cnt_nxt   = CNT_W'(bus.holdoff);
            end
          end else if (bus.filter_data > peak) begin
            // strict compare: a repeated maximum keeps the earlier timestamp
            peak_nxt    = bus.filter_data;
            peak_ts_nxt = ts;
          end
        end
      end
      HOLDOFF: begin
        if (bus.sample_valid) begin
          if (above && !prev_above) pileup_nxt = 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // losing enable abandons any open pulse without queuing it
    if (!bus.enable) begin
      state_nxt = IDLE;
      push      = 1'b0;
    end
  end

  assign push_ev = '{amp: peak, ts: peak_ts, pileup: pileup};

  event_fifo #(
    .W     ($bits(event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_dat (push_ev),
    .wr_rdy (push_rdy),
    .rd_vld (head_vld),
    .rd_rdy (bus.ev_ready),
    .rd_dat (head_ev)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      last_ev    <= '0;
    end else begin
      if (push && !push_rdy && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (head_vld) last_ev <= head_ev;
    end
  end

  // readout fields keep the last presented event once the queue empties
  assign shown_ev         = head_vld ? head_ev : last_ev;
  assign bus.ev_valid     = head_vld;
  assign bus.ev_amp       = shown_ev.amp;
  assign bus.ev_time      = shown_ev.ts;
  assign bus.ev_pileup    = shown_ev.pileup;
  assign bus.drop_cnt     = drop_cnt_q;
  assign bus.filter_clear = (state == IDLE) || (state == FLUSH);
endmodule

// File: tb/tb_filter_event_ctrl.sv
// Directed and randomized bench for filter_event_ctrl against an event-level reference model.
// The model segments the logged sample stream into pulses and holdoff windows.
module tb_filter_event_ctrl;
  localparam int W         = 16;
  localparam int TS_W      = 32;
  localparam int DEPTH     = 4;
  localparam int FLUSH_LEN = 64;

  typedef struct {
    int amp;
    int ts;
    bit pile;
  } ev_s;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   armed_cyc = 0;
  int   last_ts = 0;
  int   t200, t500;
  ev_s  got_q[$];
  ev_s  exp_q[$];
  int   log_d[$], log_ts[$], log_thr[$], log_hold[$];

  filter_event_ctrl_if #(.SIZE_FILTER_DATA(W), .TS_W(TS_W)) bus();

  filter_event_ctrl #(
    .SIZE_FILTER_DATA (W),
    .TS_W             (TS_W),
    .FIFO_DEPTH       (DEPTH),
    .FLUSH_LEN        (FLUSH_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_s e;
    if (bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
      e.amp  = int'(bus.ev_amp);
      e.ts   = int'(bus.ev_time);
      e.pile = bus.ev_pileup;
      got_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    bus.sample_valid = 1'b1;
    bus.filter_data  = 16'(d);
    last_ts = cyc - armed_cyc;
    log_d.push_back(d);
    log_ts.push_back(last_ts);
    log_thr.push_back(int'(bus.threshold));
    log_hold.push_back(int'(bus.holdoff));
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;
  endtask

  task automatic arm(input string tag);
    int n;
    n = 0;
    bus.enable = 1'b1;
    tick();
    while (bus.filter_clear === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk(tag, 64'(n), 64'(FLUSH_LEN));
    armed_cyc = cyc;
    log_d.delete(); log_ts.delete(); log_thr.delete(); log_hold.delete();
  endtask

  function automatic bit above_at(input int k);
    return log_d[k] > log_thr[k];
  endfunction

  // A pulse opens on a rising crossing, closes on the first sample at or below
  // threshold, and is followed by log_hold[close] ignored samples.
  task automatic build_model();
    int  n, i, j, pk_i, h;
    bit  prev, pile;
    ev_s e;
    n = log_d.size(); i = 0; prev = 1'b0; pile = 1'b0;
    exp_q.delete();
    while (i < n) begin
      if (!above_at(i) || prev) begin
        prev = above_at(i);
        i++;
      end else begin
        j = i; pk_i = i;
        while (j < n && above_at(j)) begin
          if (log_d[j] > log_d[pk_i]) pk_i = j;
          j++;
        end
        if (j >= n) break;
        e.amp = log_d[pk_i]; e.ts = log_ts[pk_i]; e.pile = pile;
        exp_q.push_back(e);
        pile = 1'b0;
        h = log_hold[j];
        for (int k = j + 1; k <= j + h && k < n; k++)
          if (above_at(k) && !above_at(k - 1)) pile = 1'b1;
        i = j + h + 1;
        if (i - 1 < n) prev = above_at(i - 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.threshold = 16'sd100; bus.holdoff = 8'd0;
    bus.sample_valid = 1'b0; bus.filter_data = '0; bus.ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear", 64'(bus.filter_clear), 64'(1));
    chk("rst_valid", 64'(bus.ev_valid), 64'(0));
    chk("rst_amp", 64'(bus.ev_amp), 64'(0));
    chk("rst_time", 64'(bus.ev_time), 64'(0));
    chk("rst_pileup", 64'(bus.ev_pileup), 64'(0));
    chk("rst_drop", 64'(bus.drop_cnt), 64'(0));
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_clear", 64'(bus.filter_clear), 64'(1));

    // flush length, then single pulse with ts starting at 0
    arm("flush_len");
    send(50); send(150); send(300); send(250);
    chk("pre_push_valid", 64'(bus.ev_valid), 64'(0));
    send(90);
    chk("basic_valid", 64'(bus.ev_valid), 64'(1));
    chk("basic_amp", 64'(bus.ev_amp), 64'(300));
    chk("basic_time", 64'(bus.ev_time), 64'(2));
    chk("basic_pileup", 64'(bus.ev_pileup), 64'(0));
    pop1();
    chk("basic_drained", 64'(bus.ev_valid), 64'(0));
    chk("hold_amp", 64'(bus.ev_amp), 64'(300));

    // holdoff with a re-crossing inside the window
    bus.holdoff = 8'd4;
    send(150); send(200); t200 = last_ts; send(120); send(50);
    send(80); send(120); send(80); send(60);
    send(300); send(500); t500 = last_ts; send(200); send(40);
    repeat (4) send(0);
    chk("ho_first_valid", 64'(bus.ev_valid), 64'(1));
    chk("ho_first_amp", 64'(bus.ev_amp), 64'(200));
    chk("ho_first_time", 64'(bus.ev_time), 64'(t200));
    chk("ho_first_pileup", 64'(bus.ev_pileup), 64'(0));
    pop1();
    chk("ho_second_amp", 64'(bus.ev_amp), 64'(500));
    chk("ho_second_time", 64'(bus.ev_time), 64'(t500));
    chk("ho_second_pileup", 64'(bus.ev_pileup), 64'(1));
    pop1();
    chk("ho_only_two", 64'(bus.ev_valid), 64'(0));

    // overflow: six events into four entries
    bus.holdoff = 8'd0;
    for (int k = 0; k < 6; k++) begin
      send(101 + k);
      send(0);
    end
    chk("full_drop", 64'(bus.drop_cnt), 64'(2));
    bus.ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 64'(bus.ev_valid), 64'(1));
      chk("drain_amp", 64'(bus.ev_amp), 64'(101 + k));
      tick();
    end
    chk("drain_empty", 64'(bus.ev_valid), 64'(0));
    bus.ev_ready = 1'b0;

    // disable mid-pulse discards it; queued event survives a re-flush
    send(333); send(0);
    send(200); send(400);
    bus.enable = 1'b0;
    tick();
    chk("dis_clear", 64'(bus.filter_clear), 64'(1));
    send(0);
    arm("reflush_len");
    chk("dis_keep_valid", 64'(bus.ev_valid), 64'(1));
    chk("dis_keep_amp", 64'(bus.ev_amp), 64'(333));
    chk("dis_keep_drop", 64'(bus.drop_cnt), 64'(2));
    pop1();
    chk("dis_no_peak_event", 64'(bus.ev_valid), 64'(0));

    // asynchronous reset while holding three events in HOLDOFF
    send(150); send(0); send(160); send(0);
    bus.holdoff = 8'd10;
    send(170); send(0); send(0); send(0);
    chk("pre_rst_valid", 64'(bus.ev_valid), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.ev_valid), 64'(0));
    chk("arst_amp", 64'(bus.ev_amp), 64'(0));
    chk("arst_time", 64'(bus.ev_time), 64'(0));
    chk("arst_pileup", 64'(bus.ev_pileup), 64'(0));
    chk("arst_drop", 64'(bus.drop_cnt), 64'(0));
    chk("arst_clear", 64'(bus.filter_clear), 64'(1));
    bus.enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    send(200); send(0);
    repeat (3) tick();
    chk("post_rst_no_event", 64'(bus.ev_valid), 64'(0));
    chk("post_rst_clear", 64'(bus.filter_clear), 64'(1));

    // randomized stream against the reference model
    bus.ev_ready = 1'b1;
    arm("rand_flush_len");
    got_q.delete();
    for (int s = 0; s < 600; s++) begin
      if (s % 100 == 0) begin
        bus.threshold = 16'(int'($urandom_range(0, 200)) - 50);
        bus.holdoff   = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) tick();
      send(int'($urandom_range(0, 500)) - 150);
    end
    repeat (5) tick();
    build_model();
    chk("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      chk("rand_amp", 64'(got_q[k].amp), 64'(exp_q[k].amp));
      chk("rand_time", 64'(got_q[k].ts), 64'(exp_q[k].ts));
      chk("rand_pileup", 64'(got_q[k].pile), 64'(exp_q[k].pile));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
